control_temporizador: RTL and testbench
=======================================

CONTROL_TEMPORIZADOR -- requirements
Module: control_temporizador

Interface
REQ-001 Parameter PRESCALE, default 50000, meaning clk cycles per tick; legal range 2..2^24-1.
REQ-002 Parameter TW, default 16, meaning width of tick target and tick count.
REQ-003 clk  input  1  single system clock; all logic on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 inicio  input  1  start/restart request, sampled on each clk edge.
REQ-006 pausa  input  1  level-sensitive hold while running.
REQ-007 cancelar  input  1  abort the current run and return to idle.
REQ-008 periodico  input  1  mode select: 1 = auto-reload, 0 = one-shot; latched at start.
REQ-009 objetivo  input  TW  number of ticks per run; latched at start.
REQ-010 tick_out  output  1  one-cycle pulse every PRESCALE running cycles.
REQ-011 fin  output  1  one-cycle pulse on the final tick of a run.
REQ-012 ocupado  output  1  high in states RUN and PAUSA.
REQ-013 cuenta  output  TW  ticks elapsed in the current run.
REQ-014 estado  output  2  current state: IDLE=0, RUN=1, PAUSA=2, FIN=3.

Function
REQ-015 FSM states: IDLE, RUN, PAUSA, FIN; all outputs registered.
REQ-016 Event priority per edge: reset > cancelar > inicio > pausa > prescaler advance.
REQ-017 inicio with objetivo!=0 in any state: go to RUN; latch objetivo and periodico; prescaler<=0; cuenta<=0; tick_out<=0; fin<=0.
REQ-018 inicio with objetivo==0: ignored, no state or output change.
REQ-019 inicio while in RUN or PAUSA: full restart per REQ-017; a tick due on that edge is dropped.
REQ-020 RUN, no higher-priority event: if prescaler==PRESCALE-1, then prescaler<=0, tick_out<=1, cuenta<=cuenta+1; otherwise prescaler<=prescaler+1 and tick_out<=0.
REQ-021 Tick latency: first tick_out is high in the cycle after the PRESCALE-th edge following the inicio edge; tick period is then exactly PRESCALE cycles while unpaused.
REQ-022 Final tick (tick edge with cuenta==objetivo_latched-1): fin<=1 together with tick_out.
REQ-023 Final tick, one-shot: state<=FIN and cuenta<=objetivo_latched.
REQ-024 Final tick, periodic: cuenta<=0 and state stays RUN; cuenta never exceeds objetivo_latched.
REQ-025 RUN with pausa=1: state<=PAUSA; no prescaler advance, no tick that edge; tick_out<=0.
REQ-026 PAUSA: prescaler and cuenta frozen; pausa=0 returns to RUN on the next edge, which resumes counting from the frozen prescaler value.
REQ-027 cancelar in any state: state<=IDLE; prescaler, cuenta, tick_out, fin <=0.
REQ-028 FIN: ocupado=0; cuenta holds its final value; inicio restarts; pausa ignored.
REQ-029 IDLE: pausa ignored; prescaler held at 0.
REQ-030 objetivo and periodico changes during a run have no effect until the next inicio.
REQ-031 tick_out and fin are never high for two consecutive cycles.

Reset
REQ-032 reset=1 at an edge: state<=IDLE; prescaler, cuenta, tick_out, fin, ocupado <=0; latched objetivo<=0 and latched periodico<=0; reset overrides all inputs.
REQ-033 Reset mid-run aborts without emitting fin; the block stays IDLE until a new inicio.

Verification
REQ-034 Set PRESCALE=4, objetivo=3, periodico=0, inicio pulse at edge 0 -> tick_out high after edges 4, 8, 12; fin high only after edge 12; estado=3, cuenta=3, ocupado=0.
REQ-035 Set PRESCALE=4, objetivo=2, periodico=1 -> fin after edges 8, 16, 24; cuenta sequence 1,0,1,0; ocupado stays 1.
REQ-036 Set PRESCALE=4, objetivo=2; hold pausa high for edges 2..6 -> estado=2 during the hold; first tick shifted by 5 cycles to after edge 9.
REQ-037 Drive cancelar and inicio on the same edge mid-run -> estado=0, cuenta=0, no tick_out or fin afterward.
REQ-038 Drive inicio with objetivo=0 -> estado stays 0 and tick_out stays 0 for 20 cycles.
REQ-039 Assert reset at edge 6 of a run -> all outputs 0 on the next cycle; inicio at edge 0 and at edge 2 restarts and the first tick arrives after edge 6 (relative to the second inicio).

Source files
------------

// File: rtl/control_temporizador_if.sv
// Control/status bundle between a timer client (master) and control_temporizador (slave).
interface control_temporizador_if #(
  parameter int unsigned TW = 16
);

  logic          inicio;
  logic          pausa;
  logic          cancelar;
  logic          periodico;
  logic [TW-1:0] objetivo;
  logic          tick_out;
  logic          fin;
  logic          ocupado;
  logic [TW-1:0] cuenta;
  logic [1:0]    estado;

  modport master (
    output inicio, pausa, cancelar, periodico, objetivo,
    input  tick_out, fin, ocupado, cuenta, estado
  );

  modport slave (
    input  inicio, pausa, cancelar, periodico, objetivo,
    output tick_out, fin, ocupado, cuenta, estado
  );

endinterface

// File: rtl/control_temporizador.sv
// Prescaled tick timer: counts `objetivo` ticks of PRESCALE clocks each,
// in one-shot or auto-reload mode, with pause, cancel and restart.
module control_temporizador #(
  parameter int unsigned PRESCALE = 50000,
  parameter int unsigned TW       = 16
) (
  input logic                   clk,
  input logic                   reset,
  control_temporizador_if.slave bus
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSA = 2'd2,
    FIN   = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [TW-1:0] cuenta_q, cuenta_d;
  logic [TW-1:0] obj_q, obj_d;
  logic          per_q, per_d;
  logic          tick_q, tick_d;
  logic          fin_q, fin_d;
  logic          ocupado_q, ocupado_d;
  logic          advance;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      cuenta_q  <= '0;
      obj_q     <= '0;
      per_q     <= 1'b0;
      tick_q    <= 1'b0;
      fin_q     <= 1'b0;
      ocupado_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      cuenta_q  <= cuenta_d;
      obj_q     <= obj_d;
      per_q     <= per_d;
      tick_q    <= tick_d;
      fin_q     <= fin_d;
      ocupado_q <= ocupado_d;
    end
  end

  // Next state: cancel beats start, start beats pause, pause beats counting.
  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    cuenta_d = cuenta_q;
    obj_d    = obj_q;
    per_d    = per_q;
    tick_d   = 1'b0;
    fin_d    = 1'b0;
    advance  = 1'b0;

    if (bus.cancelar) begin
      state_d  = IDLE;
      presc_d  = '0;
      cuenta_d = '0;
    end else if (bus.inicio && (bus.objetivo != '0)) begin
      // A tick falling on a restart edge is intentionally lost.
      state_d  = RUN;
      presc_d  = '0;
      cuenta_d = '0;
      obj_d    = bus.objetivo;
      per_d    = bus.periodico;
    end else begin
      case (state_q)
        RUN: begin
          if (bus.pausa) state_d = PAUSA;
          else           advance = 1'b1;
        end
        PAUSA: begin
          // The release edge already counts, so a hold of N edges delays by N.
          if (!bus.pausa) begin
            state_d = RUN;
            advance = 1'b1;
          end
        end
        IDLE:    presc_d = '0;
        default: ;
      endcase

      if (advance) begin
        if (presc_q == PRESC_LAST) begin
          presc_d = '0;
          tick_d  = 1'b1;
          if (cuenta_q == (obj_q - TW'(1))) begin
            fin_d = 1'b1;
            if (per_q) begin
              cuenta_d = '0;
            end else begin
              cuenta_d = obj_q;
              state_d  = FIN;
            end
          end else begin
            cuenta_d = cuenta_q + TW'(1);
          end
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
    end

    ocupado_d = (state_d == RUN) || (state_d == PAUSA);
  end

  assign bus.tick_out = tick_q;
  assign bus.fin      = fin_q;
  assign bus.ocupado  = ocupado_q;
  assign bus.cuenta   = cuenta_q;
  assign bus.estado   = state_q;

endmodule

// File: tb/tb_control_temporizador.sv
// Directed bench for control_temporizador with PRESCALE=4; expected outputs are
// queued with each stimulus edge and compared one cycle later.
module tb_control_temporizador;

  localparam int unsigned PRESCALE = 4;
  localparam int unsigned TW       = 16;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  control_temporizador_if #(.TW(TW)) bus ();

  control_temporizador #(
    .PRESCALE(PRESCALE),
    .TW      (TW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct packed {
    logic [1:0]    est;
    logic          tick;
    logic          fin;
    logic          ocu;
    logic [TW-1:0] cnt;
  } obs_t;

  typedef struct {
    string tag;
    obs_t  exp;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic obs_t mk(input int est, input bit tick, input bit fin,
                              input bit ocu, input int cnt);
    obs_t o;
    o.est  = 2'(est);
    o.tick = tick;
    o.fin  = fin;
    o.ocu  = ocu;
    o.cnt  = TW'(cnt);
    return o;
  endfunction

  task automatic drive(input logic rst, input logic ini, input logic pau,
                       input logic can, input logic per, input int obj);
    reset         = rst;
    bus.inicio    = ini;
    bus.pausa     = pau;
    bus.cancelar  = can;
    bus.periodico = per;
    bus.objetivo  = TW'(obj);
  endtask

  // Queue the expectation, clock one edge, then pop and compare.
  task automatic step(input string tag, input obs_t e);
    exp_t it;
    obs_t got;
    sb.push_back('{tag, e});
    @(posedge clk);
    #1;
    it  = sb.pop_front();
    got = {bus.estado, bus.tick_out, bus.fin, bus.ocupado, bus.cuenta};
    checks++;
    assert (got === it.exp) else begin
      errors++;
      $error("FAIL %s: observed est=%0d tick=%0b fin=%0b ocu=%0b cnt=%0d expected est=%0d tick=%0b fin=%0b ocu=%0b cnt=%0d",
             it.tag, got.est, got.tick, got.fin, got.ocu, got.cnt,
             it.exp.est, it.exp.tick, it.exp.fin, it.exp.ocu, it.exp.cnt);
    end
  endtask

  initial begin
    bit tk;
    bit fn;
    int st;
    int cn;

    // Reset, including a start request that must be overridden.
    drive(1, 0, 0, 0, 0, 0);
    step("reset0", mk(0, 0, 0, 0, 0));
    drive(1, 1, 0, 0, 1, 3);
    step("reset_over_inicio", mk(0, 0, 0, 0, 0));

    // One-shot, objetivo=3; mode/target changes mid-run must not matter.
    drive(0, 1, 0, 0, 0, 3);
    step("os_start", mk(1, 0, 0, 1, 0));
    for (int e = 1; e <= 12; e++) begin
      drive(0, 0, 0, 0, 1, 9);
      tk = (e % 4 == 0);
      step($sformatf("os_e%0d", e), mk(e == 12 ? 3 : 1, tk, e == 12, e != 12, e / 4));
    end
    for (int e = 13; e <= 15; e++) begin
      drive(0, 0, 1, 0, 0, 0);
      step($sformatf("os_fin_hold_e%0d", e), mk(3, 0, 0, 0, 3));
    end

    // Periodic, objetivo=2, started from FIN.
    drive(0, 1, 0, 0, 1, 2);
    step("per_start", mk(1, 0, 0, 1, 0));
    for (int e = 1; e <= 24; e++) begin
      drive(0, 0, 0, 0, 0, 0);
      tk = (e % 4 == 0);
      fn = tk && ((e / 4) % 2 == 0);
      step($sformatf("per_e%0d", e), mk(1, tk, fn, 1, (e / 4) % 2));
    end

    // Cancel together with start: cancel wins.
    drive(0, 1, 0, 1, 0, 2);
    step("cancel_inicio", mk(0, 0, 0, 0, 0));
    for (int e = 0; e < 10; e++) begin
      drive(0, 0, e[0], 0, 0, 2);
      step($sformatf("idle_after_cancel_%0d", e), mk(0, 0, 0, 0, 0));
    end

    // Pause held for edges 2..6 delays the first tick to edge 9.
    drive(0, 1, 0, 0, 0, 2);
    step("pause_start", mk(1, 0, 0, 1, 0));
    for (int e = 1; e <= 13; e++) begin
      drive(0, 0, (e >= 2 && e <= 6), 0, 0, 2);
      st = (e >= 2 && e <= 6) ? 2 : (e == 13 ? 3 : 1);
      cn = (e < 9) ? 0 : (e < 13 ? 1 : 2);
      step($sformatf("pause_e%0d", e), mk(st, e == 9 || e == 13, e == 13, e != 13, cn));
    end

    // Start with objetivo=0 is ignored.
    drive(0, 0, 0, 1, 0, 0);
    step("cancel_from_fin", mk(0, 0, 0, 0, 0));
    for (int e = 0; e < 20; e++) begin
      drive(0, 1, 0, 0, e[0], 0);
      step($sformatf("obj0_%0d", e), mk(0, 0, 0, 0, 0));
    end

    // Restart at edge 2; first tick follows 4 edges after the restart.
    drive(0, 1, 0, 0, 0, 5);
    step("rs_start", mk(1, 0, 0, 1, 0));
    drive(0, 0, 0, 0, 0, 5);
    step("rs_e1", mk(1, 0, 0, 1, 0));
    drive(0, 1, 0, 0, 0, 5);
    step("rs_e2_restart", mk(1, 0, 0, 1, 0));
    for (int e = 3; e <= 9; e++) begin
      drive(0, 0, 0, 0, 0, 5);
      step($sformatf("rs_e%0d", e), mk(1, e == 6, 0, 1, e >= 6 ? 1 : 0));
    end
    // Restart on an edge where a tick was due: tick dropped, count cleared.
    drive(0, 1, 0, 0, 0, 5);
    step("rs_drop_tick", mk(1, 0, 0, 1, 0));
    for (int e = 11; e <= 14; e++) begin
      drive(0, 0, 0, 0, 0, 5);
      step($sformatf("rs_e%0d", e), mk(1, e == 14, 0, 1, e == 14 ? 1 : 0));
    end

    // Reset at edge 6 of a fresh run aborts without fin and stays idle.
    drive(0, 1, 0, 0, 0, 2);
    step("rst_run_start", mk(1, 0, 0, 1, 0));
    for (int e = 1; e <= 5; e++) begin
      drive(0, 0, 0, 0, 0, 2);
      step($sformatf("rst_run_e%0d", e), mk(1, e == 4, 0, 1, e >= 4 ? 1 : 0));
    end
    drive(1, 1, 0, 0, 0, 2);
    step("rst_run_e6", mk(0, 0, 0, 0, 0));
    for (int e = 7; e <= 12; e++) begin
      drive(0, 0, 1, 0, 0, 2);
      step($sformatf("rst_run_idle_e%0d", e), mk(0, 0, 0, 0, 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
